ysyx_22050019_line_mem_responder: RTL and testbench

//  Read-only bus responder for the icache refill port: accepts one AR request, waits a programmable

---
 rtl/ysyx_22050019_bus_pkg.sv | 14 +
 rtl/ysyx_22050019_word_ram.sv | 26 ++
 rtl/ysyx_22050019_line_mem_responder.sv | 139 +++++++++++++
 tb/tb_ysyx_22050019_line_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_bus_pkg.sv
// Shared bus definitions for the icache refill port and its memory-side responders.
// Response codes and responder state encoding live here so both ends agree on them.
package ysyx_22050019_bus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned WaitCntWidth = 4;

endpackage

// File: rtl/ysyx_22050019_word_ram.sv
// Word-addressed storage array: one synchronous write port, one asynchronous read port.
// A write and a read of the same word on the same edge see the old contents.
module ysyx_22050019_word_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned IdxW      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IdxW-1:0]       waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IdxW-1:0]       raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_22050019_line_mem_responder.sv
// Read-only single-outstanding memory responder for the icache refill port.
// Accepts one AR, waits LATENCY extra cycles, then returns one registered R beat.
module ysyx_22050019_line_mem_responder
  import ysyx_22050019_bus_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned            LATENCY    = 2,
  localparam int unsigned           IdxW       = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [1:0]            r_resp_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  init_we_i,
  input  logic [IdxW-1:0]       init_idx_i,
  input  logic [DATA_WIDTH-1:0] init_data_i,
  output logic [31:0]           beat_cnt_o
);

  logic [1:0]              state_q, state_d;
  logic [WaitCntWidth-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    ar_ready_q, ar_ready_d;
  logic                    r_valid_q, r_valid_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
  logic [31:0]             beat_cnt_q, beat_cnt_d;

  // Extra MSB on the offset holds the borrow: set means the address is below BASE_ADDR.
  logic [ADDR_WIDTH:0]     offset;
  logic [ADDR_WIDTH-4:0]   word_idx;
  logic                    out_of_range;
  logic [IdxW-1:0]         ram_raddr;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    unused_offset_lsb;

  assign offset            = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign word_idx          = offset[ADDR_WIDTH-1:3];
  assign out_of_range      = offset[ADDR_WIDTH] | (word_idx >= (ADDR_WIDTH-3)'(MEM_DEPTH));
  assign ram_raddr         = word_idx[IdxW-1:0];
  assign unused_offset_lsb = ^offset[2:0];

  ysyx_22050019_word_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_word_ram (
    .clk_i   (clk),
    .we_i    (init_we_i),
    .waddr_i (init_idx_i),
    .wdata_i (init_data_i),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ar_valid_i && ar_ready_q) begin
          addr_d     = ar_addr_i;
          cnt_d      = WaitCntWidth'(LATENCY);
          ar_ready_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          r_valid_d = 1'b1;
          state_d   = S_RESP;
          if (out_of_range) begin
            r_resp_d = RESP_DECERR;
            r_data_d = '0;
          end else begin
            r_resp_d = RESP_OKAY;
            r_data_d = ram_rdata;
          end
        end
      end
      S_RESP: begin
        if (r_valid_q && r_ready_i) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          beat_cnt_d = beat_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_resp_o   = r_resp_q;
  assign r_data_o   = r_data_q;
  assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_ysyx_22050019_line_mem_responder.sv
// Scoreboard bench for the line memory responder: expectations are pushed at AR accept
// from a flat array model and popped by a monitor at each R handshake.
module tb_ysyx_22050019_line_mem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam longint unsigned BASE = 64'h8000_0000;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          acc;
  } exp_t;

  logic        clk, rst;
  logic        ar_valid_i, ar_ready_o;
  logic [31:0] ar_addr_i;
  logic        r_valid_o, r_ready_i;
  logic [1:0]  r_resp_o;
  logic [63:0] r_data_o;
  logic        init_we_i;
  logic [9:0]  init_idx_i;
  logic [63:0] init_data_i;
  logic [31:0] beat_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_mode = 1;

  logic [63:0] mdl_mem [DEPTH];
  exp_t        exp_q[$];
  bit          inflight = 0;
  bit          pend_inc = 0;
  bit          prev_stall = 0;
  bit          prev_valid = 0;
  logic [63:0] prev_data;
  logic [1:0]  prev_resp;
  logic [31:0] exp_beats = 0;

  ysyx_22050019_line_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .ar_addr_i   (ar_addr_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_resp_o    (r_resp_o),
    .r_data_o    (r_data_o),
    .init_we_i   (init_we_i),
    .init_idx_i  (init_idx_i),
    .init_data_i (init_data_i),
    .beat_cnt_o  (beat_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model_read(input logic [31:0] addr);
    exp_t e;
    longint unsigned a;
    a = {32'd0, addr};
    e.acc = 0;
    if (a < BASE || a >= BASE + 8 * DEPTH) begin
      e.data = 64'd0;
      e.resp = 2'b11;
    end else begin
      e.data = mdl_mem[(a - BASE) / 8];
      e.resp = 2'b00;
    end
    return e;
  endfunction

  // Monitor: samples on the falling edge, compares against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ar_ready", {63'd0, ar_ready_o}, 64'd1);
      chk("rst_r_valid", {63'd0, r_valid_o}, 64'd0);
      chk("rst_r_resp", {62'd0, r_resp_o}, 64'd0);
      chk("rst_r_data", r_data_o, 64'd0);
      chk("rst_beat_cnt", {32'd0, beat_cnt_o}, 64'd0);
      exp_q.delete();
      inflight   = 0;
      pend_inc   = 0;
      prev_stall = 0;
      prev_valid = 0;
      exp_beats  = 0;
    end else begin
      exp_t e;
      if (pend_inc) begin
        exp_beats = exp_beats + 32'd1;
        pend_inc  = 0;
      end
      chk("beat_cnt", {32'd0, beat_cnt_o}, {32'd0, exp_beats});
      chk("ar_ready", {63'd0, ar_ready_o}, {63'd0, !inflight});
      if (prev_stall) begin
        chk("stall_valid_held", {63'd0, r_valid_o}, 64'd1);
        chk("stall_data_held", r_data_o, prev_data);
        chk("stall_resp_held", {62'd0, r_resp_o}, {62'd0, prev_resp});
      end
      if (r_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", {63'd0, r_valid_o}, 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc), 64'(exp_q[0].acc + LAT + 1));
          if (r_ready_i) begin
            e = exp_q.pop_front();
            chk("r_data", r_data_o, e.data);
            chk("r_resp", {62'd0, r_resp_o}, {62'd0, e.resp});
            inflight = 0;
            pend_inc = 1;
          end
        end
      end
      prev_stall = r_valid_o && !r_ready_i;
      prev_valid = r_valid_o && !r_ready_i;
      prev_data  = r_data_o;
      prev_resp  = r_resp_o;
      // A write landing on the accept edge is visible to that read.
      if (init_we_i) mdl_mem[init_idx_i] = init_data_i;
      if (ar_valid_i && ar_ready_o) begin
        e = model_read(ar_addr_i);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        inflight = 1;
      end
    end
  end

  // Requester ready: 0 random, 1 always high, 2 held low.
  initial begin
    r_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       r_ready_i = 1'($urandom_range(0, 1));
        2:       r_ready_i = 1'b0;
        default: r_ready_i = 1'b1;
      endcase
    end
  end

  task automatic write_word(input int idx, input logic [63:0] data);
    init_we_i   = 1'b1;
    init_idx_i  = 10'(idx);
    init_data_i = data;
    @(posedge clk);
    #1;
    init_we_i = 1'b0;
  endtask

  task automatic read(input logic [31:0] addr);
    bit done = 0;
    ar_valid_i = 1'b1;
    ar_addr_i  = addr;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (ar_ready_o) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    ar_valid_i = 1'b0;
    if (!done) chk("ar_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((inflight || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = $urandom_range(0, 32'h7FFF_FFFF);
      1:       a = 32'h8000_2000 + $urandom_range(0, 4095);
      2:       a = 32'h8000_1FF8 + $urandom_range(0, 7);
      default: a = 32'h8000_0000 + $urandom_range(0, 8191);
    endcase
    return a;
  endfunction

  initial begin
    rst         = 1'b0;
    ar_valid_i  = 1'b0;
    ar_addr_i   = '0;
    init_we_i   = 1'b0;
    init_idx_i  = '0;
    init_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) write_word(i, {$urandom, $urandom});
    write_word(0, 64'h1122_3344_5566_7788);
    write_word(1, 64'hA);
    write_word(2, 64'hB);

    // Basic read, out-of-range reads and the last valid word.
    rr_mode = 1;
    read(32'h8000_0000);
    wait_idle();
    read(32'h7FFF_FFF8);
    read(32'h8000_2000);
    read(32'h8000_1FF8);
    read(32'hFFFF_FFF8);
    wait_idle();

    // Back-to-back reads; low address bits are ignored.
    read(32'h8000_0008);
    read(32'h8000_0010);
    read(32'h8000_000D);
    wait_idle();

    // Stall R for several cycles while the next AR is already held.
    rr_mode = 2;
    read(32'h8000_0018);
    fork
      begin
        repeat (LAT + 1 + 5) @(posedge clk);
        rr_mode = 1;
      end
      read(32'h8000_0020);
    join
    wait_idle();

    // Preload write on the load edge returns old data; next read sees the new word.
    write_word(1, 64'hBEEF);
    read(32'h8000_0008);
    repeat (LAT) @(posedge clk);
    #1;
    write_word(1, 64'hDEAD);
    wait_idle();
    read(32'h8000_0008);
    wait_idle();

    // Reset while waiting: transaction dropped, outputs back to idle at once.
    read(32'h8000_0000);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ar_ready", {63'd0, ar_ready_o}, 64'd1);
    chk("async_rst_r_valid", {63'd0, r_valid_o}, 64'd0);
    chk("async_rst_beat_cnt", {32'd0, beat_cnt_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    read(32'h8000_0028);
    wait_idle();

    // Randomized traffic with random R backpressure.
    rr_mode = 0;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        write_word(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
      end else begin
        read(rand_addr());
      end
    end
    rr_mode = 1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
